leaf_out_arbiter: RTL and testbench

- Shares the single leaf-to-BFT packet output between NUM_OUT_PORTS user output streams, using round-robin arbitration with per-port credit (destination freespace) flow control.
- Holds a per-port destination config (leaf, port) and a per-port destination BRAM write-address counter.
- Forms 49-bit BFT packets.
- Sits inside the leaf interface in the clk domain, between the user-side output FIFOs and the BFT output register.

---
 rtl/leaf_out_arbiter_pkg.sv | 23 ++
 rtl/leaf_out_arbiter_rr_arbiter.sv | 28 ++
 rtl/leaf_out_arbiter.sv | 132 +++++++++++++
 tb/tb_leaf_out_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/leaf_out_arbiter_pkg.sv
// Shared definitions for the leaf output arbiter: packet field layout for the
// default 49-bit BFT packet, the per-port state encoding and credit sizing.
package leaf_out_arbiter_pkg;

  // Field offsets for the default geometry {valid, leaf[5], port[4], addr[7], payload[32]}
  localparam int ADDR_LSB  = 32;
  localparam int PORT_LSB  = ADDR_LSB + 7;
  localparam int LEAF_LSB  = PORT_LSB + 4;
  localparam int VALID_BIT = LEAF_LSB + 5;

  typedef enum logic {
    UNCFG  = 1'b0,
    ACTIVE = 1'b1
  } port_state_t;

  // One extra bit so a completely free buffer (2^N words) is representable.
  function automatic int credit_width(input int bram_addr_bits);
    return bram_addr_bits + 1;
  endfunction

  localparam int CREDIT_BITS = credit_width(7);

endpackage

// File: rtl/leaf_out_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr,
// wrapping modulo N. Grant is one-hot or zero.
module rr_arbiter #(
  parameter int N = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/leaf_out_arbiter.sv
// Shares the leaf-to-BFT packet output between user output streams using
// round-robin arbitration gated by per-port destination credits.
module leaf_out_arbiter
  import leaf_out_arbiter_pkg::*;
#(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int NUM_OUT_PORTS         = 2,
  parameter int NUM_BRAM_ADDR_BITS    = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  cfg_wr_en,
  input  logic [NUM_PORT_BITS-1:0]              cfg_port,
  input  logic [NUM_LEAF_BITS-1:0]              cfg_dest_leaf,
  input  logic [NUM_PORT_BITS-1:0]              cfg_dest_port,
  input  logic                                  credit_upd_vld,
  input  logic [NUM_PORT_BITS-1:0]              credit_upd_port,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_user,
  input  logic [NUM_OUT_PORTS-1:0]              vld_user,
  output logic [NUM_OUT_PORTS-1:0]              ack_user,
  input  logic                                  stall,
  output logic [PACKET_BITS-1:0]                dout_pkt,
  output logic                                  credit_err
);

  localparam int PTR_BITS = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam int CREDIT_W = credit_width(NUM_BRAM_ADDR_BITS);
  localparam int HDR_BITS = NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS;
  localparam logic [CREDIT_W-1:0] DEPTH     = CREDIT_W'(1 << NUM_BRAM_ADDR_BITS);
  localparam logic [CREDIT_W:0]   DEPTH_EXT = {1'b0, DEPTH};
  localparam logic [CREDIT_W:0]   UPD_EXT   = (CREDIT_W + 1)'(FREESPACE_UPDATE_SIZE);

  logic [NUM_OUT_PORTS-1:0]          cfg_hit, active, req, grant, xfer, overflow;
  logic [NUM_OUT_PORTS*HDR_BITS-1:0] hdr_flat;
  logic [PTR_BITS-1:0]               rr_ptr_reg, rr_ptr_next;
  logic [PACKET_BITS-1:0]            dout_pkt_reg, pkt_next;
  logic                              credit_err_reg;

  rr_arbiter #(.N(NUM_OUT_PORTS)) u_rr (
    .req   (req),
    .ptr   (rr_ptr_reg),
    .grant (grant)
  );

  assign ack_user   = grant;
  assign xfer       = grant & vld_user;
  assign dout_pkt   = dout_pkt_reg;
  assign credit_err = credit_err_reg;

  for (genvar gi = 0; gi < NUM_OUT_PORTS; gi++) begin : g_port
    port_state_t               state_reg, state_next;
    logic [NUM_LEAF_BITS-1:0]  leaf_reg;
    logic [NUM_PORT_BITS-1:0]  port_reg;
    logic [NUM_ADDR_BITS-1:0]  addr_reg;
    logic [CREDIT_W-1:0]       credit_reg, credit_next;
    logic [CREDIT_W:0]         credit_sum;
    logic                      upd_hit, ovf;

    assign cfg_hit[gi] = cfg_wr_en && (cfg_port == NUM_PORT_BITS'(gi));
    assign active[gi]  = (state_reg == ACTIVE);
    assign upd_hit     = credit_upd_vld && (credit_upd_port == NUM_PORT_BITS'(gi)) && active[gi];
    // A port being reconfigured this cycle must not send with stale destination fields.
    assign req[gi]     = !reset && active[gi] && vld_user[gi] && (credit_reg != '0)
                         && !stall && !cfg_hit[gi];
    assign hdr_flat[gi*HDR_BITS +: HDR_BITS] = {leaf_reg, port_reg, addr_reg};
    assign overflow[gi] = ovf && !cfg_hit[gi];

    always_comb begin
      state_next = state_reg;
      if (cfg_hit[gi]) state_next = ACTIVE;
    end

    always_comb begin
      credit_sum = {1'b0, credit_reg};
      if (upd_hit)  credit_sum = credit_sum + UPD_EXT;
      if (xfer[gi]) credit_sum = credit_sum - (CREDIT_W + 1)'(1);
      ovf         = (credit_sum > DEPTH_EXT);
      credit_next = ovf ? DEPTH : credit_sum[CREDIT_W-1:0];
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_reg  <= UNCFG;
        leaf_reg   <= '0;
        port_reg   <= '0;
        addr_reg   <= '0;
        credit_reg <= DEPTH;
      end else begin
        state_reg <= state_next;
        if (cfg_hit[gi]) begin
          leaf_reg   <= cfg_dest_leaf;
          port_reg   <= cfg_dest_port;
          addr_reg   <= '0;
          credit_reg <= DEPTH;
        end else begin
          credit_reg <= credit_next;
          if (xfer[gi]) addr_reg <= addr_reg + 1'b1;
        end
      end
    end
  end

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    pkt_next    = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (xfer[i]) begin
        rr_ptr_next = PTR_BITS'((i + 1) % NUM_OUT_PORTS);
        pkt_next    = {1'b1, hdr_flat[i*HDR_BITS +: HDR_BITS],
                       din_user[i*PAYLOAD_BITS +: PAYLOAD_BITS]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_reg     <= '0;
      dout_pkt_reg   <= '0;
      credit_err_reg <= 1'b0;
    end else begin
      rr_ptr_reg   <= rr_ptr_next;
      dout_pkt_reg <= pkt_next;
      if (|overflow) credit_err_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Directed bench for leaf_out_arbiter: stimulus pushes expected packets into a
// queue, a negedge monitor pops and compares every valid dout_pkt.
module tb_leaf_out_arbiter;
  import leaf_out_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset, cfg_wr_en, credit_upd_vld, stall, credit_err;
  logic [3:0]  cfg_port, cfg_dest_port, credit_upd_port;
  logic [4:0]  cfg_dest_leaf;
  logic [63:0] din_user;
  logic [1:0]  vld_user, ack_user;
  logic [48:0] dout_pkt;

  int checks = 0;
  int passes = 0;
  logic [48:0] exp_q[$];
  logic [6:0]  a0, a1;
  logic [4:0]  l0, l1;
  logic [3:0]  p0, p1;

  always #5 clk = ~clk;

  leaf_out_arbiter dut (
    .clk(clk), .reset(reset), .cfg_wr_en(cfg_wr_en), .cfg_port(cfg_port),
    .cfg_dest_leaf(cfg_dest_leaf), .cfg_dest_port(cfg_dest_port),
    .credit_upd_vld(credit_upd_vld), .credit_upd_port(credit_upd_port),
    .din_user(din_user), .vld_user(vld_user), .ack_user(ack_user),
    .stall(stall), .dout_pkt(dout_pkt), .credit_err(credit_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [48:0] mk(input logic [4:0] l, input logic [3:0] p,
                                     input logic [6:0] a, input logic [31:0] d);
    return {1'b1, l, p, a, d};
  endfunction

  // Monitor: every valid packet must match the oldest expected entry.
  always @(negedge clk) begin
    if (dout_pkt[VALID_BIT] === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_pkt", 64'(dout_pkt), 64'd0);
      else check("pkt", 64'(dout_pkt), 64'(exp_q.pop_front()));
    end
  end

  // One clock: check the combinational ack mid-cycle, then advance; strobes are one-shot.
  task automatic tick(input string name, input logic [1:0] exp_ack);
    @(negedge clk);
    check(name, 64'(ack_user), 64'(exp_ack));
    @(posedge clk);
    #1;
    cfg_wr_en      = 1'b0;
    credit_upd_vld = 1'b0;
  endtask

  task automatic xfer(input int port, input logic [31:0] d, input string name);
    if (port == 0) begin
      din_user[31:0] = d;
      exp_q.push_back(mk(l0, p0, a0, d));
      a0 = a0 + 7'd1;
      tick(name, 2'b01);
    end else begin
      din_user[63:32] = d;
      exp_q.push_back(mk(l1, p1, a1, d));
      a1 = a1 + 7'd1;
      tick(name, 2'b10);
    end
  endtask

  task automatic cfg(input int port, input logic [4:0] l, input logic [3:0] p, input string name);
    cfg_wr_en = 1'b1; cfg_port = 4'(port); cfg_dest_leaf = l; cfg_dest_port = p;
    if (port == 0) begin l0 = l; p0 = p; a0 = 7'd0; end
    else           begin l1 = l; p1 = p; a1 = 7'd0; end
    tick(name, 2'b00);
  endtask

  initial begin
    reset = 1'b1; cfg_wr_en = 1'b0; cfg_port = '0; cfg_dest_leaf = '0; cfg_dest_port = '0;
    credit_upd_vld = 1'b0; credit_upd_port = '0; din_user = '0; vld_user = '0; stall = 1'b0;
    a0 = '0; a1 = '0; l0 = '0; l1 = '0; p0 = '0; p1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_dout", 64'(dout_pkt), 64'd0);
    check("reset_ack", 64'(ack_user), 64'd0);
    check("reset_err", 64'(credit_err), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single word to leaf 3 port 2
    vld_user = 2'b01;
    tick("uncfg_no_ack", 2'b00);
    cfg(0, 5'd3, 4'd2, "cfg_hit_no_ack");
    xfer(0, 32'hDEADBEEF, "t1_ack");
    vld_user = 2'b00;
    tick("t1_idle", 2'b00);

    // Alternation; pointer sits at 1 after the port0 grant above
    cfg(1, 5'd7, 4'd5, "cfg1");
    vld_user = 2'b11;
    for (int k = 0; k < 6; k++) xfer((k % 2 == 0) ? 1 : 0, 32'h1000_0000 + k, "rr_alt");
    vld_user = 2'b00;
    tick("t2_idle", 2'b00);

    // Exhaust port0 credit, port1 still served, then one update gives 64 more
    cfg(0, 5'd3, 4'd2, "recfg0");
    vld_user = 2'b01;
    for (int k = 0; k < 128; k++) xfer(0, 32'h2000_0000 + k, "credit_run");
    tick("credit_blocked", 2'b00);
    vld_user = 2'b11;
    xfer(1, 32'h3000_0001, "port1_while_blocked");
    xfer(1, 32'h3000_0002, "port1_while_blocked");
    vld_user = 2'b01;
    credit_upd_vld = 1'b1; credit_upd_port = 4'd0;
    tick("upd_cycle", 2'b00);
    for (int k = 0; k < 64; k++) xfer(0, 32'h4000_0000 + k, "credit_refill");
    tick("credit_reblocked", 2'b00);

    // Stall blocks everything; pointer (1) held across it
    vld_user = 2'b00;
    credit_upd_vld = 1'b1; credit_upd_port = 4'd0;
    tick("upd_idle", 2'b00);
    stall = 1'b1; vld_user = 2'b11;
    for (int k = 0; k < 5; k++) begin
      tick("stall_ack", 2'b00);
      check("stall_dout", 64'(dout_pkt), 64'd0);
    end
    stall = 1'b0;
    xfer(1, 32'h5000_0001, "post_stall");
    xfer(0, 32'h5000_0002, "post_stall");
    vld_user = 2'b00;
    tick("t4_idle", 2'b00);

    // Overflow is sticky; transfer+update at credit 10 leaves 73
    cfg(1, 5'd9, 4'd1, "recfg1");
    check("err_before", 64'(credit_err), 64'd0);
    credit_upd_vld = 1'b1; credit_upd_port = 4'd1;
    tick("ovf_upd", 2'b00);
    check("err_set", 64'(credit_err), 64'd1);
    repeat (3) tick("ovf_idle", 2'b00);
    check("err_sticky", 64'(credit_err), 64'd1);
    vld_user = 2'b10;
    for (int k = 0; k < 118; k++) xfer(1, 32'h6000_0000 + k, "drain_to_10");
    credit_upd_vld = 1'b1; credit_upd_port = 4'd1;
    xfer(1, 32'h6100_0000, "xfer_and_upd");
    for (int k = 0; k < 73; k++) xfer(1, 32'h6200_0000 + k, "drain_73");
    tick("blocked_after_73", 2'b00);

    // Reset mid-stream clears the in-flight packet and all port state
    vld_user = 2'b01;
    xfer(0, 32'h7000_0000, "pre_reset");
    reset = 1'b1;
    tick("reset_ack_mid", 2'b00);
    check("reset_dout_mid", 64'(dout_pkt), 64'd0);
    reset = 1'b0;
    check("reset_err_mid", 64'(credit_err), 64'd0);
    a0 = '0; a1 = '0;
    vld_user = 2'b11;
    tick("uncfg_both", 2'b00);
    vld_user = 2'b01;
    cfg(0, 5'd1, 4'd1, "cfg0_after_reset");
    xfer(0, 32'h8000_0001, "after_reset");
    xfer(0, 32'h8000_0002, "after_reset");
    cfg(0, 5'd4, 4'd6, "cfg0_mid_stream");
    xfer(0, 32'h8000_0003, "new_dest");
    // Out-of-range cfg and an update to an unconfigured port are both ignored
    cfg_wr_en = 1'b1; cfg_port = 4'd2; cfg_dest_leaf = 5'd31; cfg_dest_port = 4'd15;
    credit_upd_vld = 1'b1; credit_upd_port = 4'd1;
    xfer(0, 32'h8000_0004, "ignored_cfg");
    vld_user = 2'b00;
    tick("final_idle", 2'b00);
    check("err_uncfg_upd", 64'(credit_err), 64'd0);
    tick("final_idle", 2'b00);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
